// File: rtl/fcmp_arbiter.sv
// fcmp_arbiter: round-robin arbiter sharing one registered IEEE-754 single compare between
// a branch resolver (port 0) and an FPU compare-to-rd path (port 1).
// Ports:
//   clk, rstn                 clock (rising edge), synchronous active-low reset
//   req_valid[1:0]            per-port request valid
//   req_ready[1:0]            per-port accept, one-hot or zero
//   req_func3[3p+:3]          per-port op: FBEQ, FBNE, FBLT, anything else = GE
//   req_rs1/req_rs2[32p+:32]  per-port operands
//   req_tag[TAG_W*p+:TAG_W]   per-port opaque tag, returned unchanged
//   resp_valid/resp_ready     result register handshake
//   resp_id, resp_result, resp_tag  held result fields
module fcmp_arbiter #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [5:0]       req_func3,
    input  logic [63:0]      req_rs1,
    input  logic [63:0]      req_rs2,
    input  logic [2*TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic             resp_result,
    output logic [TAG_W-1:0] resp_tag
);
    localparam logic [2:0] FUNC3_FBEQ = 3'b000;
    localparam logic [2:0] FUNC3_FBNE = 3'b001;
    localparam logic [2:0] FUNC3_FBLT = 3'b100;

    logic       rr_last;
    logic       slot;
    logic       sel;
    logic [1:0] gnt;

    function automatic logic fcmp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic nan_a, nan_b, eq, lt;
        nan_a = a[30:23] == 8'hff && a[22:0] != 23'd0;
        nan_b = b[30:23] == 8'hff && b[22:0] != 23'd0;
        eq = a == b || {a, b} == {32'h0000_0000, 32'h8000_0000} || {a, b} == {32'h8000_0000, 32'h0000_0000};
        // -0 < +0 must be false; same-sign magnitudes order as unsigned, reversed when negative
        lt = nan_a || nan_b || {a, b} == {32'h8000_0000, 32'h0000_0000} ? 1'b0 :
             a[31] != b[31] ? a[31] :
             a[31] ? a[30:0] > b[30:0] : a[30:0] < b[30:0];
        fcmp = f == FUNC3_FBEQ ? eq : f == FUNC3_FBNE ? !eq : f == FUNC3_FBLT ? lt : !lt;
    endfunction

    // slot never looks at resp_ready while the register is empty
    always_comb begin
        slot = !resp_valid || resp_ready;
        gnt = !rstn || !slot ? 2'b00 : &req_valid ? (rr_last ? 2'b01 : 2'b10) : req_valid;
        sel = gnt[1];
        req_ready = gnt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= 1'b0;
            resp_tag    <= '0;
            rr_last     <= 1'b1;
        end else if (|gnt) begin
            resp_valid  <= 1'b1;
            resp_id     <= sel;
            resp_result <= fcmp(req_func3[3*sel+:3], req_rs1[32*sel+:32], req_rs2[32*sel+:32]);
            resp_tag    <= req_tag[TAG_W*sel+:TAG_W];
            rr_last     <= sel;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fcmp_arbiter.sv
// tb_fcmp_arbiter: directed vectors, corner sequences and randomized reference-model check of fcmp_arbiter.
module tb_fcmp_arbiter;
    localparam int TAG_W = 5;
    localparam logic [2:0] FBEQ = 3'b000, FBNE = 3'b001, FBLT = 3'b100, FBGE = 3'b101;

    logic clk = 0, rstn = 0, resp_ready = 0;
    logic [1:0] req_valid = 0, req_ready;
    logic [5:0] req_func3 = 0;
    logic [63:0] req_rs1 = 0, req_rs2 = 0;
    logic [2*TAG_W-1:0] req_tag = 0;
    logic resp_valid, resp_id, resp_result;
    logic [TAG_W-1:0] resp_tag;

    int chk_cnt = 0, pass_cnt = 0;

    fcmp_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_func3(req_func3), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_tag(resp_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_port(input int p, input logic v, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] t);
        req_valid[p] = v;
        req_func3[3*p+:3] = f;
        req_rs1[32*p+:32] = a;
        req_rs2[32*p+:32] = b;
        req_tag[TAG_W*p+:TAG_W] = t;
    endtask

    // Reference compare: map each float onto a signed integer ordering key (+0 and -0 both 0)
    function automatic logic ref_cmp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint ka, kb;
        logic na, nb, eq, lt;
        ka = {33'd0, a[30:0]};
        kb = {33'd0, b[30:0]};
        if (a[31]) ka = -ka;
        if (b[31]) kb = -kb;
        na = a[30:23] == 8'hff && a[22:0] != 0;
        nb = b[30:23] == 8'hff && b[22:0] != 0;
        eq = a == b || (!na && !nb && ka == kb);
        lt = !na && !nb && ka < kb;
        case (f)
            FBEQ: return eq;
            FBNE: return !eq;
            FBLT: return lt;
            default: return !lt;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7fc0_0000;
            3: return {$urandom_range(1, 0) == 1, 8'hff, 23'($urandom_range(1, 8))};
            4: return 32'h7f80_0000;
            5: return 32'hff80_0000;
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[14];
    logic m_valid, m_id, m_res, m_last;
    logic [TAG_W-1:0] m_tag;
    logic [1:0] m_gnt, pend;
    int g;

    initial begin
        vecs[0]  = '{FBEQ, 32'h0000_0000, 32'h8000_0000, 1'b1};
        vecs[1]  = '{FBNE, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[2]  = '{FBLT, 32'h7fc0_0000, 32'h3f80_0000, 1'b0};
        vecs[3]  = '{FBGE, 32'h7fc0_0000, 32'h3f80_0000, 1'b1};
        vecs[4]  = '{FBLT, 32'hbf80_0000, 32'hc000_0000, 1'b0};
        vecs[5]  = '{FBLT, 32'hc000_0000, 32'hbf80_0000, 1'b1};
        vecs[6]  = '{FBLT, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{FBLT, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[8]  = '{FBEQ, 32'h7fc0_0000, 32'h7fc0_0000, 1'b1};
        vecs[9]  = '{FBEQ, 32'h7fc0_0000, 32'h7fc0_0001, 1'b0};
        vecs[10] = '{FBLT, 32'h3f80_0000, 32'h4000_0000, 1'b1};
        vecs[11] = '{FBLT, 32'hbf80_0000, 32'h3f80_0000, 1'b1};
        vecs[12] = '{3'b111, 32'h7f80_0000, 32'h7f7f_ffff, 1'b1};
        vecs[13] = '{FBNE, 32'h3f80_0000, 32'h3f80_0001, 1'b1};

        // reset state, requests ignored while in reset
        req_valid = 2'b11;
        resp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_tag", resp_tag, 0);
        chk("reset_req_ready", req_ready, 0);
        req_valid = 0;
        rstn = 1;

        // directed compare table, alternating ports
        for (int i = 0; i < 14; i++) begin
            set_port(i % 2, 1, vecs[i].f, vecs[i].a, vecs[i].b, TAG_W'(i));
            #1 chk("vec_ready", req_ready, (i % 2) ? 2'b10 : 2'b01);
            @(negedge clk);
            set_port(i % 2, 0, 0, 0, 0, 0);
            chk("vec_valid", resp_valid, 1);
            chk("vec_id", resp_id, i % 2);
            chk($sformatf("vec%0d_result", i), resp_result, vecs[i].exp);
            chk("vec_tag", resp_tag, i);
        end

        // alternating grants from reset
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        set_port(0, 1, FBEQ, 32'h1, 32'h1, 5'd3);
        set_port(1, 1, FBNE, 32'h1, 32'h1, 5'd9);
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_ready", req_ready, (k % 2) ? 2'b10 : 2'b01);
            @(negedge clk);
            chk("rr_valid", resp_valid, 1);
            chk("rr_id", resp_id, k % 2);
            chk("rr_tag", resp_tag, (k % 2) ? 9 : 3);
            chk("rr_result", resp_result, (k % 2) ? 0 : 1);
        end

        // backpressure hold then same-cycle drain+refill
        resp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_ready", req_ready, 0);
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_id", resp_id, 1);
            chk("hold_tag", resp_tag, 9);
        end
        resp_ready = 1;
        #1 chk("refill_ready", req_ready, 2'b01);
        @(negedge clk);
        chk("refill_valid", resp_valid, 1);
        chk("refill_id", resp_id, 0);
        chk("refill_tag", resp_tag, 3);

        // reset mid-flight; next tie goes to port 0 although port 0 won last
        resp_ready = 0;
        rstn = 0;
        req_valid = 2'b01;
        #1 chk("rst_ready", req_ready, 0);
        @(negedge clk);
        chk("rst_valid", resp_valid, 0);
        rstn = 1;
        resp_ready = 1;
        req_valid = 2'b11;
        #1 chk("rst_tie_ready", req_ready, 2'b01);
        @(negedge clk);
        chk("rst_tie_id", resp_id, 0);

        // port 0 withdraws while stalled; port 1 granted alone
        resp_ready = 0;
        set_port(0, 1, FBEQ, 0, 0, 5'd21);
        req_valid[1] = 0;
        #1 chk("wd_stall_ready", req_ready, 0);
        @(negedge clk);
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 1, FBLT, 32'h3f80_0000, 32'h4000_0000, 5'd17);
        #1 chk("wd_stall2_ready", req_ready, 0);
        @(negedge clk);
        resp_ready = 1;
        #1 chk("wd_ready", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 0;
        chk("wd_id", resp_id, 1);
        chk("wd_tag", resp_tag, 17);
        chk("wd_result", resp_result, 1);
        @(negedge clk);
        chk("wd_drain", resp_valid, 0);

        // randomized run against the reference model
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        m_valid = 0; m_id = 0; m_res = 0; m_tag = 0; m_last = 1; pend = 0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_valid", resp_valid, m_valid);
            chk("rnd_id", resp_id, m_id);
            chk("rnd_result", resp_result, m_res);
            chk("rnd_tag", resp_tag, m_tag);
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) begin
                    if ($urandom % 6 == 0) req_valid[p] = 0;
                end else begin
                    logic [31:0] a;
                    a = pick();
                    set_port(p, $urandom % 3 != 0, 3'($urandom), a, ($urandom % 4 == 0) ? a : pick(),
                             TAG_W'($urandom));
                end
            end
            resp_ready = $urandom % 4 != 0;
            rstn = $urandom % 80 != 0;
            // reference: who should be granted this cycle (-1 = nobody)
            if (!rstn || (m_valid && !resp_ready) || req_valid == 0) g = -1;
            else if (req_valid == 2'b11) g = m_last ? 0 : 1;
            else g = req_valid[1] ? 1 : 0;
            m_gnt = (g < 0) ? 2'b00 : 2'(1 << g);
            #1 chk("rnd_ready", req_ready, m_gnt);
            pend = req_valid & ~m_gnt;
            if (!rstn) begin
                m_valid = 0; m_id = 0; m_res = 0; m_tag = 0; m_last = 1; pend = 0;
            end else if (g >= 0) begin
                m_valid = 1;
                m_id = g[0];
                m_res = ref_cmp(req_func3[3*g+:3], req_rs1[32*g+:32], req_rs2[32*g+:32]);
                m_tag = req_tag[TAG_W*g+:TAG_W];
                m_last = g[0];
            end else if (resp_ready) m_valid = 0;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
